// File: rtl/alarma_pkg.sv
// Phase encoding shared by the alarm arming controller, its bus interface and the bench.
package alarma_pkg;

  localparam int FASE_W = 3;

  typedef enum logic [FASE_W-1:0] {
    DESARMADO = 3'b000,
    SALIDA    = 3'b001,
    ARMADO    = 3'b010,
    ENTRADA   = 3'b011,
    ALARMA    = 3'b100,
    BLOQUEO   = 3'b101
  } fase_e;

  // Phases in which the system counts as armed (BLOQUEO keeps whatever it inherited).
  function automatic logic fase_armada(input fase_e f);
    return f inside {SALIDA, ARMADO, ENTRADA, ALARMA};
  endfunction

  function automatic logic fase_vigilada(input fase_e f);
    return f inside {ARMADO, ENTRADA, ALARMA};
  endfunction

endpackage

// File: rtl/control_alarma_if.sv
// Keypad/sensor inputs and FSM/display outputs of control_alarma grouped as one bus.
interface control_alarma_if
  import alarma_pkg::*;
#(
  parameter int CW = 6
);
  logic              tick_1hz;
  logic              btn_armar;
  logic              codigo_ok;
  logic              codigo_err;
  logic              mov;
  logic              pres;
  logic              led_pelig;
  logic              en_maq;
  logic              armado;
  logic              sirena;
  logic [CW-1:0]     cuenta;
  logic [FASE_W-1:0] fase;

  modport master (
    output tick_1hz, btn_armar, codigo_ok, codigo_err, mov, pres, led_pelig,
    input  en_maq, armado, sirena, cuenta, fase
  );

  modport slave (
    input  tick_1hz, btn_armar, codigo_ok, codigo_err, mov, pres, led_pelig,
    output en_maq, armado, sirena, cuenta, fase
  );
endinterface

// File: rtl/control_alarma_contador_seg.sv
// Loadable seconds down-counter; fin flags the tick that consumes the last second.
module contador_seg #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] val,
  input  logic          tick,
  output logic [CW-1:0] cnt,
  output logic          fin
);
  logic [CW-1:0] cnt_reg;

  // A load always wins over a tick so a phase change sees its fresh duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= val;
    end else if (tick && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign cnt = cnt_reg;
  assign fin = tick & (cnt_reg == CW'(1));
endmodule

// File: rtl/control_alarma.sv
// Arming/sequencing controller for the alarm FSM: exit/entry delays, siren timeout, keypad.
// Optional wrong-code lockout phase is compiled in with `define BLOQUEO_EN.
module control_alarma
  import alarma_pkg::*;
#(
  parameter int CW        = 6,
  parameter int T_SALIDA  = 30,
  parameter int T_ENTRADA = 15,
  parameter int T_SIRENA  = 60,
  parameter int MAX_INT   = 3,
  parameter int T_BLOQ    = 30
) (
  input logic             clk,
  input logic             rst_n,
  control_alarma_if.slave bus
);
  fase_e         fase_reg, fase_next;
  logic          en_reg, en_next;
  logic          armado_reg, armado_next;
  logic          sirena_reg, sirena_next;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic [CW-1:0] cnt;
  logic          fin;
  logic          lock_hit;

  contador_seg #(.CW(CW)) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .val   (cnt_val),
    .tick  (bus.tick_1hz),
    .cnt   (cnt),
    .fin   (fin)
  );

`ifdef BLOQUEO_EN
  logic [1:0] err_cnt_reg, err_cnt_next;

  assign lock_hit = (fase_reg inside {DESARMADO, SALIDA, ARMADO, ENTRADA, ALARMA}) &&
                    !bus.codigo_ok && bus.codigo_err &&
                    (int'(err_cnt_reg) == MAX_INT - 1);

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (fase_reg == BLOQUEO) begin
      if (fase_next != BLOQUEO) err_cnt_next = '0;
    end else if (bus.codigo_ok) begin
      err_cnt_next = '0;
    end else if (bus.codigo_err) begin
      err_cnt_next = err_cnt_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_reg <= '0;
    else        err_cnt_reg <= err_cnt_next;
  end
`else
  localparam int unused_lock_params = MAX_INT + T_BLOQ;
  logic unused_err;
  assign lock_hit   = 1'b0;
  assign unused_err = bus.codigo_err;
`endif

  // codigo_ok is tested first in every armed phase: disarm beats timeouts and sensors.
  always_comb begin
    fase_next = fase_reg;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (fase_reg)
      DESARMADO: if (bus.btn_armar) begin
        fase_next = SALIDA;
        cnt_load  = 1'b1;
        cnt_val   = CW'(T_SALIDA);
      end
      SALIDA: if (bus.codigo_ok || fin) begin
        fase_next = bus.codigo_ok ? DESARMADO : ARMADO;
        cnt_load  = 1'b1;
      end
      ARMADO: begin
        if (bus.codigo_ok) begin
          fase_next = DESARMADO;
          cnt_load  = 1'b1;
        end else if (bus.led_pelig) begin
          fase_next = ALARMA;
          cnt_load  = 1'b1;
          cnt_val   = CW'(T_SIRENA);
        end else if (bus.mov || bus.pres) begin
          fase_next = ENTRADA;
          cnt_load  = 1'b1;
          cnt_val   = CW'(T_ENTRADA);
        end
      end
      ENTRADA: begin
        if (bus.codigo_ok) begin
          fase_next = DESARMADO;
          cnt_load  = 1'b1;
        end else if (bus.led_pelig || fin) begin
          fase_next = ALARMA;
          cnt_load  = 1'b1;
          cnt_val   = CW'(T_SIRENA);
        end
      end
      ALARMA: if (bus.codigo_ok || fin) begin
        fase_next = bus.codigo_ok ? DESARMADO : ARMADO;
        cnt_load  = 1'b1;
      end
`ifdef BLOQUEO_EN
      BLOQUEO: if (fin) begin
        fase_next = armado_reg ? ALARMA : DESARMADO;
        cnt_load  = 1'b1;
        cnt_val   = armado_reg ? CW'(T_SIRENA) : '0;
      end
`endif
      default: begin
        fase_next = DESARMADO;
        cnt_load  = 1'b1;
      end
    endcase
    if (lock_hit) begin
      fase_next = BLOQUEO;
      cnt_load  = 1'b1;
      cnt_val   = CW'(T_BLOQ);
    end
  end

  // Lockout freezes the indicators of the phase it interrupted and only forces the siren.
  always_comb begin
    en_next     = fase_vigilada(fase_next);
    armado_next = fase_armada(fase_next);
    sirena_next = (fase_next == ALARMA);
    if (fase_next == BLOQUEO) begin
      en_next     = en_reg;
      armado_next = armado_reg;
      sirena_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase_reg   <= DESARMADO;
      en_reg     <= 1'b0;
      armado_reg <= 1'b0;
      sirena_reg <= 1'b0;
    end else begin
      fase_reg   <= fase_next;
      en_reg     <= en_next;
      armado_reg <= armado_next;
      sirena_reg <= sirena_next;
    end
  end

  assign bus.fase   = fase_reg;
  assign bus.cuenta = cnt;
  assign bus.en_maq = en_reg;
  assign bus.armado = armado_reg;
  assign bus.sirena = sirena_reg;
endmodule

// File: tb/tb_control_alarma.sv
// Self-checking bench for control_alarma against a phase/seconds-remaining reference model.
module tb_control_alarma;
  localparam int CW        = 6;
  localparam int T_SALIDA  = 3;
  localparam int T_ENTRADA = 2;
  localparam int T_SIRENA  = 4;
  localparam int MAX_INT   = 3;
  localparam int T_BLOQ    = 2;

  localparam int P_DES = 0, P_SAL = 1, P_ARM = 2, P_ENT = 3, P_ALA = 4, P_BLQ = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  control_alarma_if #(.CW(CW)) bus ();

  control_alarma #(
    .CW(CW), .T_SALIDA(T_SALIDA), .T_ENTRADA(T_ENTRADA),
    .T_SIRENA(T_SIRENA), .MAX_INT(MAX_INT), .T_BLOQ(T_BLOQ)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: which phase, how many seconds are left, and the indicator lamps.
  int m_phase, m_left, m_errs;
  bit m_en, m_arm, m_sir;

  task automatic model_reset();
    m_phase = P_DES; m_left = 0; m_errs = 0;
    m_en = 0; m_arm = 0; m_sir = 0;
  endtask

  task automatic model_step(input bit tick, btn, ok, err, mv, pr, lp);
    int  nxt;
    int  left;
    bit  expired;
    nxt     = m_phase;
    expired = tick && (m_left == 1);
    left    = (tick && m_left > 0) ? m_left - 1 : m_left;
    case (m_phase)
      P_DES: if (btn) begin nxt = P_SAL; left = T_SALIDA; end
      P_SAL: if (ok) nxt = P_DES; else if (expired) nxt = P_ARM;
      P_ARM: begin
        if (ok) nxt = P_DES;
        else if (lp) begin nxt = P_ALA; left = T_SIRENA; end
        else if (mv || pr) begin nxt = P_ENT; left = T_ENTRADA; end
      end
      P_ENT: begin
        if (ok) nxt = P_DES;
        else if (lp || expired) begin nxt = P_ALA; left = T_SIRENA; end
      end
      P_ALA: if (ok) nxt = P_DES; else if (expired) nxt = P_ARM;
      P_BLQ: if (expired) begin
        nxt  = m_arm ? P_ALA : P_DES;
        left = m_arm ? T_SIRENA : 0;
      end
      default: nxt = P_DES;
    endcase
`ifdef BLOQUEO_EN
    if (m_phase != P_BLQ) begin
      if (ok) m_errs = 0;
      else if (err) begin
        m_errs++;
        if (m_errs == MAX_INT) begin nxt = P_BLQ; left = T_BLOQ; end
      end
    end else if (nxt != P_BLQ) begin
      m_errs = 0;
    end
`endif
    if (nxt == P_DES || nxt == P_ARM) left = 0;
    if (nxt == P_BLQ) begin
      m_sir = 1;
    end else begin
      m_en  = (nxt == P_ARM || nxt == P_ENT || nxt == P_ALA);
      m_arm = (nxt >= P_SAL && nxt <= P_ALA);
      m_sir = (nxt == P_ALA);
    end
    m_phase = nxt;
    m_left  = left;
  endtask

  function automatic logic [11:0] exp_vec();
    logic [2:0] p;
    logic [5:0] l;
    p = 3'(m_phase);
    l = 6'(m_left);
    return {p, l, m_en, m_arm, m_sir};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {bus.fase, bus.cuenta, bus.en_maq, bus.armado, bus.sirena};
  endfunction

  // One transaction: present inputs, let one rising edge sample them, advance the model.
  task automatic drive(input bit tick, btn, ok, err, mv, pr, lp);
    bus.tick_1hz = tick; bus.btn_armar = btn; bus.codigo_ok = ok; bus.codigo_err = err;
    bus.mov = mv; bus.pres = pr; bus.led_pelig = lp;
    @(posedge clk);
    model_step(tick, btn, ok, err, mv, pr, lp);
    #1;
    bus.tick_1hz = 0; bus.btn_armar = 0; bus.codigo_ok = 0; bus.codigo_err = 0;
    bus.mov = 0; bus.pres = 0; bus.led_pelig = 0;
    $display("t=%0t in t%0b b%0b ok%0b e%0b m%0b p%0b lp%0b -> fase=%0d cuenta=%0d en=%0b arm=%0b sir=%0b",
             $time, tick, btn, ok, err, mv, pr, lp, bus.fase, bus.cuenta,
             bus.en_maq, bus.armado, bus.sirena);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    bus.tick_1hz = 0; bus.btn_armar = 0; bus.codigo_ok = 0; bus.codigo_err = 0;
    bus.mov = 0; bus.pres = 0; bus.led_pelig = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_armed();
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (T_SALIDA) drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    hard_reset();
    n_checks++;
    if (obs_vec() !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), 12'h000);
    end
    drive(0, 0, 1, 0, 1, 1, 1);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_ok_ignored: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_arm_exit();
    hard_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.cuenta !== 6'd3) begin
      n_fail++;
      $display("FAIL arm_load: got %h want %h", obs_vec(), exp_vec());
    end
    // Sensors and a repeated arm request must not disturb the exit delay.
    for (int i = 0; i < T_SALIDA; i++) begin
      drive(1, 1, 0, 0, 1, 1, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL arm_exit tick %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({bus.fase, bus.en_maq, bus.armado, bus.sirena} !== {3'b010, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL armed_outputs: got fase=%b en=%b arm=%b sir=%b want 010 1 1 0",
               bus.fase, bus.en_maq, bus.armado, bus.sirena);
    end
  endtask

  task automatic test_entry_alarm();
    hard_reset();
    go_armed();
    drive(0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.fase !== 3'b011 || bus.cuenta !== 6'd2) begin
      n_fail++;
      $display("FAIL entry_start: got %h want %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < T_ENTRADA + T_SIRENA; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL entry_alarm tick %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.fase !== 3'b010 || bus.sirena !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm: got fase=%b sir=%b want 010 0", bus.fase, bus.sirena);
    end
  endtask

  task automatic test_ok_priority();
    hard_reset();
    go_armed();
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 1, 1, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || obs_vec() !== 12'h000) begin
      n_fail++;
      $display("FAIL ok_beats_tick: got %h want %h", obs_vec(), 12'h000);
    end
  endtask

  task automatic test_fire();
    hard_reset();
    go_armed();
    drive(0, 0, 0, 0, 1, 1, 1);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.fase !== 3'b100 || bus.cuenta !== 6'd4) begin
      n_fail++;
      $display("FAIL fire_path: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

`ifdef BLOQUEO_EN
  task automatic test_lockout();
    hard_reset();
    go_armed();
    repeat (MAX_INT) drive(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.fase !== 3'b101 || bus.sirena !== 1'b1) begin
      n_fail++;
      $display("FAIL lockout_entry: got %h want %h", obs_vec(), exp_vec());
    end
    drive(0, 0, 1, 0, 0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.fase !== 3'b101) begin
      n_fail++;
      $display("FAIL lockout_ok_ignored: got %h want %h", obs_vec(), exp_vec());
    end
    repeat (T_BLOQ) drive(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.fase !== 3'b100) begin
      n_fail++;
      $display("FAIL lockout_exit: got %h want %h", obs_vec(), exp_vec());
    end
  endtask
`else
  task automatic test_err_ignored();
    hard_reset();
    go_armed();
    repeat (MAX_INT + 1) drive(0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.fase !== 3'b010) begin
      n_fail++;
      $display("FAIL err_ignored: got %h want %h", obs_vec(), exp_vec());
    end
  endtask
`endif

  task automatic test_async_reset();
    hard_reset();
    go_armed();
    drive(0, 0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_vec() !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs_vec(), 12'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 1, 1, 1);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL no_resume: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    bit tk, bt, ok, er, mv, pr, lp;
    hard_reset();
    for (int i = 0; i < 400; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      bt = ($urandom_range(0, 7) == 0);
      ok = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 9) == 0);
      mv = ($urandom_range(0, 9) == 0);
      pr = ($urandom_range(0, 9) == 0);
      lp = ($urandom_range(0, 19) == 0);
      drive(tk, bt, ok, er, mv, pr, lp);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_arm_exit();
    test_entry_alarm();
    test_ok_priority();
    test_fire();
`ifdef BLOQUEO_EN
    test_lockout();
`else
    test_err_ignored();
`endif
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
